// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter between a Z80-style CPU (stalled via WAIT_n) and a GPU fetch port.
// Optional stall statistics counter enabled by defining VRAM_ARB_STATS_EN.
module vram_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 8,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_wait_n,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              gpu_req,
    input  logic [ADDR_W-1:0] gpu_addr,
    output logic              gpu_ack,
    output logic              gpu_rvalid,
    output logic [DATA_W-1:0] gpu_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [15:0]       stat_cpu_stall
);

    typedef enum logic [1:0] {IDLE, CPU_ISSUE, CPU_HOLD} state_t;

    state_t            state_q;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              cpu_we_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              gpu_rvalid_q;
    logic [DATA_W-1:0] gpu_rdata_q;

    logic cpu_prio, cpu_issue, gpu_issue;

    // Reset gates every issue path so no RAM cycle can start while rst is high.
    assign cpu_prio  = (wait_cnt_q >= 4'(CPU_MAX_WAIT));
    assign cpu_issue = !rst && (state_q == IDLE) && cpu_req && (!gpu_req || cpu_prio);
    assign gpu_issue = !rst && (state_q != CPU_ISSUE) && gpu_req && !cpu_issue;

    assign ram_en   = cpu_issue | gpu_issue;
    assign ram_we   = cpu_issue & cpu_we;
    assign ram_addr = cpu_issue ? cpu_addr : gpu_addr;
    assign ram_din  = cpu_issue ? cpu_wdata : '0;

    assign gpu_ack    = gpu_issue;
    assign cpu_wait_n = !(cpu_req && !rst && (state_q != CPU_HOLD));
    assign cpu_rdata  = cpu_rdata_q;
    assign gpu_rvalid = gpu_rvalid_q;
    // RAM output register supplies the data in the rvalid cycle; the copy holds it afterwards.
    assign gpu_rdata  = gpu_rvalid_q ? ram_dout : gpu_rdata_q;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == IDLE) begin
            if (cpu_issue)
                wait_cnt_d = 4'd0;
            else if (cpu_req && wait_cnt_q != 4'hF)
                wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wait_cnt_q   <= 4'd0;
            cpu_we_q     <= 1'b0;
            cpu_rdata_q  <= '0;
            gpu_rvalid_q <= 1'b0;
            gpu_rdata_q  <= '0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            gpu_rvalid_q <= gpu_issue;
            if (gpu_rvalid_q)
                gpu_rdata_q <= ram_dout;
            case (state_q)
                IDLE: begin
                    if (cpu_issue) begin
                        state_q  <= CPU_ISSUE;
                        cpu_we_q <= cpu_we;
                    end
                end
                CPU_ISSUE: begin
                    if (!cpu_we_q)
                        cpu_rdata_q <= ram_dout;
                    state_q <= cpu_req ? CPU_HOLD : IDLE;
                end
                CPU_HOLD: begin
                    if (!cpu_req)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!cpu_wait_n && cpu_req && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= 16'd0;
        else     stall_q <= stall_d;
    end

    assign stat_cpu_stall = stall_q;
`else
    assign stat_cpu_stall = 16'd0;
`endif

endmodule
